// File: rtl/mdu_pkg.sv
// rtl/mdu_pkg.sv - MDU opcode encodings, FSM states and latency defaults.
package mdu_pkg;

    localparam logic [4:0] OP_MFHI  = 5'h10;
    localparam logic [4:0] OP_MTHI  = 5'h11;
    localparam logic [4:0] OP_MFLO  = 5'h12;
    localparam logic [4:0] OP_MTLO  = 5'h13;
    localparam logic [4:0] OP_MULT  = 5'h18;
    localparam logic [4:0] OP_MULTU = 5'h19;
    localparam logic [4:0] OP_DIV   = 5'h1A;
    localparam logic [4:0] OP_DIVU  = 5'h1B;

    localparam int MUL_LAT_DEF = 5;
    localparam int DIV_LAT_DEF = 10;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_MUL  = 2'd1,
        ST_DIV  = 2'd2
    } mdu_state_e;

endpackage

// File: rtl/mdu_core.sv
// rtl/mdu_core.sv - combinational 64-bit multiply and 32-bit divide datapath.
module mdu_core (
    input  logic [31:0] i_rs,
    input  logic [31:0] i_rt,
    input  logic        i_signed,
    input  logic        i_div,
    output logic [31:0] o_hi,
    output logic [31:0] o_lo
);

    logic [63:0] w_a64;
    logic [63:0] w_b64;
    logic [63:0] w_prod;
    logic        w_neg_a;
    logic        w_neg_b;
    logic [31:0] w_mag_a;
    logic [31:0] w_mag_b;
    logic [31:0] w_divisor;
    logic [31:0] w_uq;
    logic [31:0] w_ur;
    logic [31:0] w_q;
    logic [31:0] w_r;

    assign w_a64  = i_signed ? {{32{i_rs[31]}}, i_rs} : {32'd0, i_rs};
    assign w_b64  = i_signed ? {{32{i_rt[31]}}, i_rt} : {32'd0, i_rt};
    assign w_prod = w_a64 * w_b64;

    // Divide on magnitudes so 0x80000000 / -1 wraps to 0x80000000 with no overflow special case.
    assign w_neg_a   = i_signed & i_rs[31];
    assign w_neg_b   = i_signed & i_rt[31];
    assign w_mag_a   = w_neg_a ? (~i_rs + 32'd1) : i_rs;
    assign w_mag_b   = w_neg_b ? (~i_rt + 32'd1) : i_rt;
    assign w_divisor = (i_rt == 32'd0) ? 32'd1 : w_mag_b;
    assign w_uq      = w_mag_a / w_divisor;
    assign w_ur      = w_mag_a % w_divisor;
    assign w_q       = (w_neg_a ^ w_neg_b) ? (~w_uq + 32'd1) : w_uq;
    assign w_r       = w_neg_a ? (~w_ur + 32'd1) : w_ur;

    always_comb begin
        o_hi = w_prod[63:32];
        o_lo = w_prod[31:0];
        if (i_div) begin
            if (i_rt == 32'd0) begin
                o_hi = i_rs;
                o_lo = 32'hFFFF_FFFF;
            end else begin
                o_hi = w_r;
                o_lo = w_q;
            end
        end
    end

endmodule

// File: rtl/mdu_ctrl.sv
// rtl/mdu_ctrl.sv - MDU sequencer: FSM, latency counter, HI/LO; MDU_DIV0_HOLD_EN drops divide-by-zero.
module mdu_ctrl
    import mdu_pkg::*;
#(
    parameter int MUL_LAT = MUL_LAT_DEF,
    parameter int DIV_LAT = DIV_LAT_DEF
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        start,
    input  logic [4:0]  op,
    input  logic [31:0] rs,
    input  logic [31:0] rt,
    input  logic        d_mdu_use,
    output logic        busy,
    output logic        stall,
    output logic [31:0] hi,
    output logic [31:0] lo,
    output logic [31:0] mdu_out
);

    localparam logic [4:0] MUL_CNT = 5'(MUL_LAT - 1);
    localparam logic [4:0] DIV_CNT = 5'(DIV_LAT - 1);

    mdu_state_e  r_state;
    logic [4:0]  r_cnt;
    logic [31:0] r_hi;
    logic [31:0] r_lo;
    logic [31:0] r_res_hi;
    logic [31:0] r_res_lo;

    logic        w_is_mul;
    logic        w_is_div;
    logic        w_div_go;
    logic        w_signed;
    logic [31:0] w_core_hi;
    logic [31:0] w_core_lo;

    assign w_is_mul = (op == OP_MULT) || (op == OP_MULTU);
    assign w_is_div = (op == OP_DIV) || (op == OP_DIVU);
    assign w_signed = (op == OP_MULT) || (op == OP_DIV);

`ifdef MDU_DIV0_HOLD_EN
    assign w_div_go = w_is_div && (rt != 32'd0);
`else
    assign w_div_go = w_is_div;
`endif

    mdu_core u_core (
        .i_rs     (rs),
        .i_rt     (rt),
        .i_signed (w_signed),
        .i_div    (w_is_div),
        .o_hi     (w_core_hi),
        .o_lo     (w_core_lo)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state  <= ST_IDLE;
            r_cnt    <= 5'd0;
            r_hi     <= 32'd0;
            r_lo     <= 32'd0;
            r_res_hi <= 32'd0;
            r_res_lo <= 32'd0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (start) begin
                        if (w_is_mul) begin
                            r_res_hi <= w_core_hi;
                            r_res_lo <= w_core_lo;
                            r_cnt    <= MUL_CNT;
                            r_state  <= ST_MUL;
                        end else if (w_div_go) begin
                            r_res_hi <= w_core_hi;
                            r_res_lo <= w_core_lo;
                            r_cnt    <= DIV_CNT;
                            r_state  <= ST_DIV;
                        end else if (op == OP_MTHI) begin
                            r_hi <= rs;
                        end else if (op == OP_MTLO) begin
                            r_lo <= rs;
                        end
                    end
                end
                default: begin
                    // New starts are deliberately not looked at while an operation is in flight.
                    if (r_cnt == 5'd0) begin
                        r_hi    <= r_res_hi;
                        r_lo    <= r_res_lo;
                        r_state <= ST_IDLE;
                    end else begin
                        r_cnt <= r_cnt - 5'd1;
                    end
                end
            endcase
        end
    end

    assign busy  = (r_state != ST_IDLE);
    assign stall = d_mdu_use & (busy | (start & (w_is_mul | w_is_div)));
    assign hi    = r_hi;
    assign lo    = r_lo;

    always_comb begin
        mdu_out = 32'd0;
        if (op == OP_MFHI) begin
            mdu_out = r_hi;
        end else if (op == OP_MFLO) begin
            mdu_out = r_lo;
        end
    end

endmodule

// File: tb/tb_mdu_ctrl.sv
// tb/tb_mdu_ctrl.sv - directed scoreboard bench for mdu_ctrl; honours MDU_DIV0_HOLD_EN.
module tb_mdu_ctrl;
    import mdu_pkg::*;

    localparam logic [4:0] OP_NONE = 5'h00;
    localparam logic [4:0] OP_BAD  = 5'h05;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        start;
    logic [4:0]  op;
    logic [31:0] rs;
    logic [31:0] rt;
    logic        d_mdu_use;
    logic        busy;
    logic        stall;
    logic [31:0] hi;
    logic [31:0] lo;
    logic [31:0] mdu_out;

    int          n_checks = 0;
    int          n_fail = 0;
    logic [63:0] sb[$];

    mdu_ctrl dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .start     (start),
        .op        (op),
        .rs        (rs),
        .rt        (rt),
        .d_mdu_use (d_mdu_use),
        .busy      (busy),
        .stall     (stall),
        .hi        (hi),
        .lo        (lo),
        .mdu_out   (mdu_out)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $fatal(1, "FAIL watchdog timeout");
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
        end
    endtask

    task automatic chk_result(input string tag);
        logic [63:0] e;
        e = sb.pop_front();
        chk({tag, "_hi"}, hi, e[63:32]);
        chk({tag, "_lo"}, lo, e[31:0]);
    endtask

    function automatic logic [63:0] m_mul(input logic [31:0] a, input logic [31:0] b, input bit sgn);
        logic signed [63:0] ps;
        logic [63:0]        pu;
        ps = $signed(a) * $signed(b);
        pu = {32'd0, a} * {32'd0, b};
        return sgn ? ps : pu;
    endfunction

    function automatic logic [63:0] m_div(input logic [31:0] a, input logic [31:0] b, input bit sgn);
        longint x, y, q, r;
        if (b == 32'd0) return {a, 32'hFFFF_FFFF};
        x = sgn ? longint'($signed(a)) : longint'({32'd0, a});
        y = sgn ? longint'($signed(b)) : longint'({32'd0, b});
        q = x / y;
        r = x % y;
        return {r[31:0], q[31:0]};
    endfunction

    // One op; inj>0 injects a MULT start during that busy cycle.
    task automatic run_op(input logic [4:0] o, input logic [31:0] a, input logic [31:0] b,
                          input int inj, output int nb, output int ns);
        @(posedge clk); #1;
        start = 1'b1; op = o; rs = a; rt = b;
        #1;
        ns = stall ? 1 : 0;
        @(posedge clk); #1;
        start = 1'b0; op = OP_NONE;
        nb = 0;
        while (busy && nb < 64) begin
            if (stall) ns++;
            nb++;
            if (nb == inj) begin
                start = 1'b1; op = OP_MULT; rs = 32'd7; rt = 32'd9;
            end else begin
                start = 1'b0; op = OP_NONE;
            end
            @(posedge clk); #1;
        end
        start = 1'b0; op = OP_NONE;
    endtask

    initial begin
        int nb, ns;
        logic [31:0] a, b, ph, pl;

        rst_n = 1'b0; start = 1'b0; op = OP_NONE; rs = 32'd0; rt = 32'd0; d_mdu_use = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_busy", {31'd0, busy}, 32'd0);
        chk("rst_hi", hi, 32'd0);
        chk("rst_lo", lo, 32'd0);
        d_mdu_use = 1'b1;
        #1;
        chk("rst_stall_idle", {31'd0, stall}, 32'd0);
        start = 1'b1; op = OP_MULT;
        #1;
        chk("rst_stall_start", {31'd0, stall}, 32'd1);
        op = OP_MFHI;
        #1;
        chk("rst_mdu_out", mdu_out, 32'd0);
        start = 1'b0; op = OP_NONE;
        @(posedge clk); #1;
        rst_n = 1'b1;

        sb.push_back(64'hFFFF_FFFF_FFFF_FFFA);
        run_op(OP_MULT, 32'hFFFF_FFFE, 32'd3, -1, nb, ns);
        chk("mult_busy_cycles", nb, 32'd5);
        chk("mult_stall_cycles", ns, 32'd6);
        chk("mult_stall_after", {31'd0, stall}, 32'd0);
        chk_result("mult_spec");

        d_mdu_use = 1'b0;
        a = 32'h8000_0001; b = 32'h7FFF_FFFF;
        sb.push_back(m_mul(a, b, 1'b1));
        run_op(OP_MULT, a, b, -1, nb, ns);
        chk("mult_nouse_stall", ns, 32'd0);
        chk_result("mult_neg");

        for (int i = 0; i < 3; i++) begin
            a = $urandom; b = $urandom;
            sb.push_back(m_mul(a, b, 1'b0));
            run_op(OP_MULTU, a, b, -1, nb, ns);
            chk("multu_busy_cycles", nb, 32'd5);
            chk_result("multu_rand");
        end

        sb.push_back({32'd2, 32'd14});
        run_op(OP_DIVU, 32'd100, 32'd7, -1, nb, ns);
        chk("divu_busy_cycles", nb, 32'd10);
        chk_result("divu_spec");

        sb.push_back({32'hFFFF_FFFF, 32'hFFFF_FFFD});
        run_op(OP_DIV, 32'hFFFF_FFF9, 32'd2, -1, nb, ns);
        chk("div_busy_cycles", nb, 32'd10);
        chk_result("div_spec");

        sb.push_back({32'd0, 32'h8000_0000});
        run_op(OP_DIV, 32'h8000_0000, 32'hFFFF_FFFF, -1, nb, ns);
        chk_result("div_overflow");

        for (int i = 0; i < 3; i++) begin
            a = $urandom; b = $urandom;
            if (b == 32'd0) b = 32'd1;
            sb.push_back(m_div(a, b, 1'b1));
            run_op(OP_DIV, a, b, -1, nb, ns);
            chk_result("div_rand");
            b = b >> (i * 8 + 4);
            if (b == 32'd0) b = 32'd3;
            sb.push_back(m_div(a, b, 1'b0));
            run_op(OP_DIVU, a, b, -1, nb, ns);
            chk_result("divu_rand");
        end

        ph = hi; pl = lo;
`ifdef MDU_DIV0_HOLD_EN
        sb.push_back({ph, pl});
        run_op(OP_DIV, 32'd5, 32'd0, -1, nb, ns);
        chk("div0_busy_cycles", nb, 32'd0);
`else
        sb.push_back({32'd5, 32'hFFFF_FFFF});
        run_op(OP_DIV, 32'd5, 32'd0, -1, nb, ns);
        chk("div0_busy_cycles", nb, 32'd10);
`endif
        chk_result("div0");

        ph = hi; pl = lo;
        run_op(OP_MTHI, 32'h1234_5678, 32'd0, -1, nb, ns);
        chk("mthi_busy_cycles", nb, 32'd0);
        start = 1'b1; op = OP_MFHI;
        #1;
        chk("mfhi_out", mdu_out, 32'h1234_5678);
        @(posedge clk); #1;
        start = 1'b0;
        chk("mfhi_busy", {31'd0, busy}, 32'd0);
        chk("mthi_lo_kept", lo, pl);
        run_op(OP_MTLO, 32'hABCD_EF01, 32'd0, -1, nb, ns);
        op = OP_MFLO;
        #1;
        chk("mflo_out", mdu_out, 32'hABCD_EF01);
        op = OP_NONE;
        #1;
        chk("mdu_out_other", mdu_out, 32'd0);

        sb.push_back({32'd3, 32'd100});
        run_op(OP_DIVU, 32'd1003, 32'd10, 3, nb, ns);
        chk("inject_busy_cycles", nb, 32'd10);
        chk_result("inject");

        ph = hi; pl = lo;
        run_op(OP_BAD, 32'hFFFF_0000, 32'd3, -1, nb, ns);
        chk("badop_busy_cycles", nb, 32'd0);
        chk("badop_hi", hi, ph);
        chk("badop_lo", lo, pl);

        @(posedge clk); #1;
        start = 1'b1; op = OP_MULT; rs = 32'd3; rt = 32'd4;
        @(posedge clk); #1;
        start = 1'b0; op = OP_NONE;
        @(posedge clk); #1;
        @(posedge clk); #1;
        chk("abort_busy_before", {31'd0, busy}, 32'd1);
        rst_n = 1'b0;
        #1;
        chk("abort_busy", {31'd0, busy}, 32'd0);
        chk("abort_hi", hi, 32'd0);
        chk("abort_lo", lo, 32'd0);
        @(posedge clk); #1;
        rst_n = 1'b1;
        repeat (8) @(posedge clk);
        #1;
        chk("abort_late_hi", hi, 32'd0);
        chk("abort_late_lo", lo, 32'd0);
        chk("abort_late_busy", {31'd0, busy}, 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
